fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined processor.
- Owns the program counter and drives the byte address into the instruction memory, which returns a combinational 32-bit big-endian word.
- Registers the fetched word into the IF/ID pipeline register consumed by the decode stage.
- Handles stall, branch/jump redirect from EX, halt, and an optional static branch predictor.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 512, instruction memory size in bytes; power of two, >= 8.
- NOP_WORD, 32'h0000_0000, word inserted into IF/ID on bubble or flush.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- imem_addr  out  32  byte address to instruction memory; equals pc
- imem_data  in  32  instruction word at imem_addr, same cycle
- stall  in  1  decode hazard; hold PC and IF/ID
- halt  in  1  stop fetching; sticky until rst
- redirect_valid  in  1  EX resolved a taken branch/jump or a mispredict
- redirect_target  in  32  new PC when redirect_valid
- id_instr  out  32  IF/ID instruction
- id_pc  out  32  IF/ID PC of id_instr
- id_pc_plus4  out  32  IF/ID PC+4, wrapped
- id_valid  out  1  IF/ID holds a real instruction
- id_pred_taken  out  1  predictor chose taken; always 0 when feature is compiled out
- halted  out  1  FSM is in HALTED

Behaviour:
- FSM states: BOOT, RUN, HALTED; 2-bit encoding.
- Reset (rst=1 at a clock edge):
  - state=BOOT, pc=RESET_PC.
  - id_instr=NOP_WORD, id_pc=0, id_pc_plus4=0, id_valid=0, id_pred_taken=0, halted=0.
- BOOT: one cycle with no fetch, because instruction memory initialises while rst is high. Always goes to RUN; pc is unchanged and id_valid stays 0.
- RUN, evaluated per clock in this priority order:
  1. redirect_valid:
     - pc <= {redirect_target[31:2],2'b00} mod IMEM_BYTES
     - IF/ID <= bubble (id_valid=0, id_instr=NOP_WORD)
     - Overrides stall and halt in the same cycle.
  2. halt: state <= HALTED, IF/ID <= bubble, pc held.
  3. stall: pc and all id_* hold their current values. No bubble; decode re-reads the same instruction.
  4. Otherwise:
     - IF/ID <= {imem_data, pc, pc+4}, id_valid=1.
     - pc <= next_pc.
- next_pc:
  - (pc+4) mod IMEM_BYTES; pc = IMEM_BYTES-4 wraps to 0.
  - Replaced by the predicted target when the predictor fires.
- HALTED: pc frozen, id_valid=0, halted=1. Redirect, stall and halt are ignored; only rst exits.
- Address rules:
  - pc[1:0] is always 00.
  - All PC arithmetic is 32-bit, masked to log2(IMEM_BYTES) bits.
  - imem_addr = pc, combinational from the register.
- Latency:
  - Instruction at pc appears on id_* one clock after pc is presented.
  - First valid id_instr is 2 clocks after rst deasserts: BOOT, then the fetch edge.
  - Redirect costs 1 bubble: target word is valid on id_* 2 clocks after the redirect edge.
- Reset mid-operation: rst wins over everything; state returns to BOOT.

Optional Feature:
- Macro: FETCH_STATIC_PREDICT_EN.
- Defined:
  - Predecoder on imem_data detects beq/bne (opcode 6'b000100/6'b000101) whose 16-bit immediate is negative (backward branch).
  - Predicted target = pc+4 + (sext(imm)<<2), masked to IMEM_BYTES; this becomes next_pc.
  - id_pred_taken=1 for that instruction. EX issues redirect_valid on mispredict.
  - Forward branches are predicted not-taken.
- Undefined: next_pc is always pc+4; id_pred_taken is tied to 0; no predecoder logic.

Decomposition:
- Shared package proc_pkg:
  - OPC_BEQ, OPC_BNE, INSTR_W=32.
  - fetch_state_t enum {BOOT,RUN,HALTED}.
  - if_id_t struct {instr, pc, pc_plus4, valid, pred_taken}.
- Sub-module branch_predecode: combinational, imem_data + pc -> hit, target. Instantiated only under FETCH_STATIC_PREDICT_EN.

Test Plan:
- Reset release, no stall:
  - Cycle 1: imem_addr=0.
  - Cycle 2: id_instr=32'h00430820, id_pc=0, id_valid=1.
  - Cycle 3: id_pc=4, instr 32'h00430822.
  - Cycle 4: id_pc=8, instr 32'h00620820.
- Stall at pc=4 for 3 cycles: imem_addr stays 4; id_pc stays 0 with id_valid=1. On release, id_pc=4 next cycle.
- Redirect with redirect_target=32'h0000_0103 while stall=1:
  - Next cycle: pc=0x100, id_valid=0.
  - Cycle after: id_pc=0x100, id_valid=1.
- Wrap, IMEM_BYTES=512: pc=0x1FC with no stall -> next imem_addr=0, and id_pc_plus4=0 for that instruction.
- halt at pc=8: halted=1 and id_valid=0 next cycle. redirect_valid=1 afterwards leaves pc=8. rst returns to BOOT, then pc=0.
- With FETCH_STATIC_PREDICT_EN, beq imm=16'hFFFE at pc=0x10 -> next imem_addr=0x0C and id_pred_taken=1. Forward beq imm=2 -> next imem_addr=0x14, id_pred_taken=0.

Source files
------------

// File: rtl/proc_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the pipelined processor front end.
//   INSTR_W        : instruction width in bits
//   OPC_BEQ/OPC_BNE: primary opcodes of the conditional branches
//   fetch_state_t  : fetch-stage FSM states
//   if_id_t        : contents of the IF/ID pipeline register
//   wrap_pc()      : folds a byte address into the instruction memory and
//                    forces word alignment
// -----------------------------------------------------------------------------
package proc_pkg;

    localparam int INSTR_W = 32;

    localparam logic [5:0] OPC_BEQ = 6'b000100;
    localparam logic [5:0] OPC_BNE = 6'b000101;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
        logic [31:0]        pc_plus4;
        logic               valid;
        logic               pred_taken;
    } if_id_t;

    // mask is (memory size - 1) with the two low bits already cleared, so one
    // AND both wraps the address and keeps it word aligned.
    function automatic logic [31:0] wrap_pc(input logic [31:0] addr,
                                            input logic [31:0] mask);
        return addr & mask;
    endfunction

endpackage

// File: rtl/branch_predecode.sv
// -----------------------------------------------------------------------------
// branch_predecode
// Combinational predecoder for the static backward-taken predictor. Flags a
// beq/bne whose 16-bit immediate is negative and computes its target.
// Ports:
//   imem_data  in  32  word currently returned by instruction memory
//   pc         in  32  address of imem_data
//   hit        out 1   backward beq/bne: predict taken
//   target     out 32  pc+4 + (sext(imm) << 2), wrapped into IMEM_BYTES
// -----------------------------------------------------------------------------
module branch_predecode
    import proc_pkg::*;
#(
    parameter int IMEM_BYTES = 512
) (
    input  logic [31:0] imem_data,
    input  logic [31:0] pc,
    output logic        hit,
    output logic [31:0] target
);

    localparam logic [31:0] PC_MASK = 32'(IMEM_BYTES - 1) & 32'hFFFF_FFFC;

    logic [5:0]  opcode;
    logic [15:0] imm;
    logic [31:0] offset;
    logic        unused_fields;

    // Register fields are irrelevant to the prediction.
    assign unused_fields = ^imem_data[25:16];

    // Only the sign of the immediate matters for the direction decision;
    // forward branches fall through to pc+4.
    always_comb begin
        opcode = imem_data[31:26];
        imm    = imem_data[15:0];
        offset = {{14{imm[15]}}, imm, 2'b00};
        hit    = ((opcode == OPC_BEQ) || (opcode == OPC_BNE)) && imm[15];
        target = wrap_pc(pc + 32'd4 + offset, PC_MASK);
    end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction memory and fills the IF/ID pipeline register.
// Optional feature macro: FETCH_STATIC_PREDICT_EN (static backward-taken
// prediction of beq/bne; when undefined id_pred_taken is tied to 0).
// Ports:
//   clk              in  1   rising-edge clock
//   rst              in  1   synchronous active-high reset
//   imem_addr        out 32  byte address to instruction memory (= pc)
//   imem_data        in  32  instruction at imem_addr, same cycle
//   stall            in  1   hold PC and IF/ID
//   halt             in  1   stop fetching, sticky until rst
//   redirect_valid   in  1   EX redirect (taken branch/jump or mispredict)
//   redirect_target  in  32  new PC on redirect
//   id_instr         out 32  IF/ID instruction
//   id_pc            out 32  IF/ID PC
//   id_pc_plus4      out 32  IF/ID PC+4, wrapped
//   id_valid         out 1   IF/ID holds a real instruction
//   id_pred_taken    out 1   predictor chose taken
//   halted           out 1   FSM in HALTED
// -----------------------------------------------------------------------------
module fetch_stage
    import proc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 512,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid,
    output logic        id_pred_taken,
    output logic        halted
);

    localparam logic [31:0] PC_MASK = 32'(IMEM_BYTES - 1) & 32'hFFFF_FFFC;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    if_id_t       if_id_q, if_id_d;

    logic [31:0]  pc_plus4;
    logic [31:0]  next_pc;
    logic         pred_hit;
    logic [31:0]  pred_target;

    assign pc_plus4 = wrap_pc(pc_q + 32'd4, PC_MASK);

`ifdef FETCH_STATIC_PREDICT_EN
    branch_predecode #(
        .IMEM_BYTES (IMEM_BYTES)
    ) u_predecode (
        .imem_data (imem_data),
        .pc        (pc_q),
        .hit       (pred_hit),
        .target    (pred_target)
    );
`else
    assign pred_hit    = 1'b0;
    assign pred_target = pc_plus4;
`endif

    assign next_pc = pred_hit ? pred_target : pc_plus4;

    // Next-state logic. Within RUN the order redirect > halt > stall > fetch
    // matters: a redirect must squash the wrong-path word even when decode is
    // stalled or a halt is being requested in the same cycle. Bubbles keep
    // the previous id_pc/id_pc_plus4 since they are meaningless when invalid.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if_id_d = if_id_q;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_d               = wrap_pc(redirect_target, PC_MASK);
                    if_id_d.instr      = NOP_WORD;
                    if_id_d.valid      = 1'b0;
                    if_id_d.pred_taken = 1'b0;
                end else if (halt) begin
                    state_d            = HALTED;
                    if_id_d.instr      = NOP_WORD;
                    if_id_d.valid      = 1'b0;
                    if_id_d.pred_taken = 1'b0;
                end else if (!stall) begin
                    if_id_d.instr      = imem_data;
                    if_id_d.pc         = pc_q;
                    if_id_d.pc_plus4   = pc_plus4;
                    if_id_d.valid      = 1'b1;
                    if_id_d.pred_taken = pred_hit;
                    pc_d               = next_pc;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State, PC and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= BOOT;
            pc_q               <= RESET_PC;
            if_id_q.instr      <= NOP_WORD;
            if_id_q.pc         <= 32'h0;
            if_id_q.pc_plus4   <= 32'h0;
            if_id_q.valid      <= 1'b0;
            if_id_q.pred_taken <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
        end
    end

    assign imem_addr     = pc_q;
    assign id_instr      = if_id_q.instr;
    assign id_pc         = if_id_q.pc;
    assign id_pc_plus4   = if_id_q.pc_plus4;
    assign id_valid      = if_id_q.valid;
    assign id_pred_taken = if_id_q.pred_taken;
    assign halted        = (state_q == HALTED);

endmodule
